ifetch_responder: RTL and testbench

- Instruction-fetch responder. It sits on the other side of the next-PC generator.
- It accepts fetch addresses through a valid/ready handshake and reads a word-addressed instruction memory with fixed latency.
- Results are buffered in an output FIFO and delivered to decode in request order.
- A flush input discards all queued and in-flight fetches when a jump or redirect is taken.

---
 rtl/ifetch_responder.sv | 146 ++++++++++++++
 tb/tb_ifetch_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: fixed-latency word-memory read behind a credit-
// controlled valid/ready front end, with an in-order output FIFO and flush.
module ifetch_responder #(
    parameter int ADDR_BITS  = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          fetch_addr,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic                 flush,
    output logic [31:0]          instr_out,
    output logic [31:0]          instr_pc,
    output logic                 instr_err,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int OCC_W    = PTR_BITS + 2;
    // Stage 0 is the accept cycle itself; the last stage below feeds the FIFO write.
    localparam int PIPE     = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [31:0]          mem [2**ADDR_BITS];

    logic                 accept;
    logic [ADDR_BITS-1:0] word_idx;
    logic                 addr_err;
    logic [31:0]          rd_word;

    logic                 pipe_valid [PIPE];
    logic [31:0]          pipe_data  [PIPE];
    logic [31:0]          pipe_pc    [PIPE];
    logic                 pipe_err   [PIPE];

    logic                 push;
    logic [31:0]          push_data;
    logic [31:0]          push_pc;
    logic                 push_err;
    logic                 pop;

    logic [31:0]          fifo_data [FIFO_DEPTH];
    logic [31:0]          fifo_pc   [FIFO_DEPTH];
    logic                 fifo_err  [FIFO_DEPTH];
    logic [PTR_BITS:0]    wptr;
    logic [PTR_BITS:0]    rptr;
    logic                 fifo_empty;

    logic [OCC_W-1:0]     inflight;
    logic [OCC_W-1:0]     occupancy;

    always_comb begin
        word_idx = fetch_addr[ADDR_BITS+1:2];
        addr_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_BITS+2] != '0);
        rd_word  = addr_err ? 32'h0 : mem[word_idx];
        accept   = fetch_valid && fetch_ready && !flush;
    end

    // Program load; the read above sees the pre-edge contents on a same-cycle collision.
    always_ff @(posedge clock) begin
        if (load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int k = 0; k < PIPE; k++)
                pipe_valid[k] <= 1'b0;
        end else begin
            pipe_valid[0] <= accept;
            for (int k = 1; k < PIPE; k++)
                pipe_valid[k] <= pipe_valid[k-1];
        end
    end

    always_ff @(posedge clock) begin
        pipe_data[0] <= rd_word;
        pipe_pc[0]   <= fetch_addr;
        pipe_err[0]  <= addr_err;
        for (int k = 1; k < PIPE; k++) begin
            pipe_data[k] <= pipe_data[k-1];
            pipe_pc[k]   <= pipe_pc[k-1];
            pipe_err[k]  <= pipe_err[k-1];
        end
    end

    always_comb begin
        if (LATENCY == 1) begin
            push      = accept;
            push_data = rd_word;
            push_pc   = fetch_addr;
            push_err  = addr_err;
        end else begin
            push      = pipe_valid[PIPE-1];
            push_data = pipe_data[PIPE-1];
            push_pc   = pipe_pc[PIPE-1];
            push_err  = pipe_err[PIPE-1];
        end
    end

    // Credits count everything already promised a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        inflight = '0;
        if (LATENCY > 1) begin
            for (int k = 0; k < PIPE; k++)
                inflight = inflight + OCC_W'(pipe_valid[k]);
        end
        occupancy   = inflight + {1'b0, wptr - rptr};
        fetch_ready = (occupancy < OCC_W'(FIFO_DEPTH));
    end

    always_comb begin
        fifo_empty  = (wptr == rptr);
        instr_valid = !fifo_empty;
        pop         = !fifo_empty && instr_ready;
        instr_out   = fifo_empty ? 32'h0 : fifo_data[rptr[PTR_BITS-1:0]];
        instr_pc    = fifo_empty ? 32'h0 : fifo_pc[rptr[PTR_BITS-1:0]];
        instr_err   = fifo_empty ? 1'b0  : fifo_err[rptr[PTR_BITS-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + (PTR_BITS+1)'(1);
            if (pop)
                rptr <= rptr + (PTR_BITS+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wptr[PTR_BITS-1:0]] <= push_data;
            fifo_pc[wptr[PTR_BITS-1:0]]   <= push_pc;
            fifo_err[wptr[PTR_BITS-1:0]]  <= push_err;
        end
    end

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder: directed scenarios followed by random
// traffic, all compared against a queue-based model of outstanding fetches.
module tb_ifetch_responder;

    localparam int ADDR_BITS  = 8;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_err;
    logic        instr_valid;
    logic        instr_ready;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    ifetch_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_err  (instr_err),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
        int          due;
    } resp_t;

    // Every accepted, not-yet-popped fetch; it becomes visible once cyc reaches due.
    resp_t       q[$];
    logic [31:0] ref_mem [256];
    int          cyc;
    int          vectors;
    int          miscompares;

    function automatic resp_t makeResp(input logic [31:0] a);
        resp_t r;
        r.pc   = a;
        r.err  = (a[1:0] != 2'b00) || (a >= 32'h400);
        r.data = r.err ? 32'h0 : ref_mem[a[9:2]];
        r.due  = cyc + LATENCY;
        return r;
    endfunction

    function automatic logic headVisible();
        return (q.size() > 0) && (cyc >= q[0].due);
    endfunction

    task automatic checkOutput();
        logic        exp_vld;
        logic        exp_rdy;
        logic        exp_err;
        logic [31:0] exp_out;
        logic [31:0] exp_pc;
        exp_vld = headVisible();
        exp_out = 32'h0;
        exp_pc  = 32'h0;
        exp_err = 1'b0;
        if (exp_vld) begin
            exp_out = q[0].data;
            exp_pc  = q[0].pc;
            exp_err = q[0].err;
        end
        exp_rdy = (q.size() < FIFO_DEPTH);

        vectors++;
        assert (instr_valid === exp_vld) else begin
            miscompares++;
            $error("[TB] FAIL instr_valid cyc %0d: observed %b expected %b", cyc, instr_valid, exp_vld);
        end
        vectors++;
        assert (instr_out === exp_out) else begin
            miscompares++;
            $error("[TB] FAIL instr_out cyc %0d: observed %h expected %h", cyc, instr_out, exp_out);
        end
        vectors++;
        assert (instr_pc === exp_pc) else begin
            miscompares++;
            $error("[TB] FAIL instr_pc cyc %0d: observed %h expected %h", cyc, instr_pc, exp_pc);
        end
        vectors++;
        assert (instr_err === exp_err) else begin
            miscompares++;
            $error("[TB] FAIL instr_err cyc %0d: observed %b expected %b", cyc, instr_err, exp_err);
        end
        vectors++;
        assert (fetch_ready === exp_rdy) else begin
            miscompares++;
            $error("[TB] FAIL fetch_ready cyc %0d: observed %b expected %b", cyc, fetch_ready, exp_rdy);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model across the edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] addr, input logic fl,
                                 input logic ir, input logic le, input logic [7:0] la,
                                 input logic [31:0] ld);
        logic exp_rdy;
        logic exp_vld;
        fetch_valid = fv;
        fetch_addr  = addr;
        flush       = fl;
        instr_ready = ir;
        load_en     = le;
        load_addr   = la;
        load_data   = ld;
        @(negedge clock);
        checkOutput();
        exp_rdy = (q.size() < FIFO_DEPTH);
        exp_vld = headVisible();
        if (reset || fl) begin
            q.delete();
        end else begin
            if (exp_vld && ir)
                q.delete(0);
            if (fv && exp_rdy)
                q.push_back(makeResp(addr));
        end
        if (le)
            ref_mem[la] = ld;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic ir);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 32'h0, 1'b0, ir, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic doFetch(input logic [31:0] a, input logic ir);
        applyStimulus(1'b1, a, 1'b0, ir, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic doLoad(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_addr  = 32'h0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        load_en     = 1'b0;
        load_addr   = 8'h0;
        load_data   = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] preload memory");
        for (int i = 0; i < 256; i++)
            doLoad(8'(i), $urandom());
        doLoad(8'd0, 32'h11111111);
        doLoad(8'd1, 32'h22222222);
        doLoad(8'd2, 32'h33333333);
        doLoad(8'd3, 32'h44444444);

        $display("[TB] basic fetch");
        doFetch(32'h0, 1'b1);
        doFetch(32'h4, 1'b1);
        doFetch(32'h8, 1'b1);
        idle(4, 1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++)
            doFetch(32'(i * 4), 1'b0);
        idle(2, 1'b0);
        doFetch(32'h18, 1'b1);
        doFetch(32'h18, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        $display("[TB] flush mid-stream");
        doFetch(32'h0, 1'b0);
        doFetch(32'h4, 1'b0);
        doFetch(32'hC, 1'b0);
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 8'h0, 32'h0);
        idle(3, 1'b1);
        doFetch(32'h8, 1'b1);
        idle(3, 1'b1);

        $display("[TB] error entries");
        doFetch(32'h2, 1'b0);
        doFetch(32'h400, 1'b0);
        doFetch(32'h4, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        $display("[TB] reset mid-operation");
        doFetch(32'h0, 1'b0);
        doFetch(32'h4, 1'b0);
        doFetch(32'h8, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        idle(4, 1'b1);
        doFetch(32'h0, 1'b1);
        idle(3, 1'b1);

        $display("[TB] load/read collision");
        doLoad(8'd1, 32'hAAAAAAAA);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 8'd1, 32'hBBBBBBBB);
        idle(3, 1'b1);
        doFetch(32'h4, 1'b1);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic        le;
            a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0)
                a = $urandom();
            reset = ($urandom_range(0, 59) == 0);
            le    = !reset && ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 2) != 0, le, 8'($urandom_range(0, 255)), $urandom());
        end
        reset = 1'b0;
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
